// File: rtl/gat_bram_stream_loader_if.sv
// gat_bram_stream_loader_if
// Bundles the host AXI-Stream input and the BRAM write port of one loader.
// Handshake: a beat transfers on a rising clk edge where s_axis_tvalid and
// s_axis_tready are both high; the source holds tdata/tlast stable while
// tvalid is high without tready, and tready never depends on tvalid.
interface gat_bram_stream_loader_if #(
    parameter int ADDR_W = 18
);
    logic [31:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [31:0]       bram_din;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W+1:0] bram_addra;

    // Loader side: consumes the stream, drives the BRAM port.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output bram_din, bram_ena, bram_wea, bram_addra
    );

    // Host/DMA side: produces the stream, observes the BRAM port.
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  bram_din, bram_ena, bram_wea, bram_addra
    );
endinterface

// File: rtl/gat_bram_stream_loader.sv
// gat_bram_stream_loader
// Streams a 32-bit image from the host DMA into one GAT input BRAM.
// Each accepted beat is written one cycle later at byte address
// {word_index, 2'b00}. load_done / load_err are sticky until the next start.
// Optional build macro LOADER_CHECKSUM_EN adds a running 32-bit sum of all
// accepted words on the checksum output.
module gat_bram_stream_loader #(
    parameter int DATA_DEPTH = 242101,
    parameter int ADDR_W     = $clog2(DATA_DEPTH),
    parameter int CNT_W      = ADDR_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    gat_bram_stream_loader_if.slave bus,
    output logic                    load_done,
    output logic                    load_err,
    output logic                    busy,
    output logic [CNT_W-1:0]        word_count,
    output logic [1:0]              state_dbg
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]             checksum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  ptr_q;
    logic              accept;
    logic              arm;

    logic [31:0]       din_q;
    logic [ADDR_W+1:0] addra_q;
    logic              strobe_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, beat acceptance and the arm (restart) strobe.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        arm     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    arm     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // start is deliberately ignored here: no mid-load restart.
                accept = bus.s_axis_tvalid;
                if (accept) begin
                    if (bus.s_axis_tlast) begin
                        state_d = ST_DONE;
                    end else if (ptr_q == LAST_IDX) begin
                        // Last slot filled without tlast: the image is too big.
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    arm     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word pointer: cleared on every (re)start, advances per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (arm) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_q + ONE;
        end
    end

    // Registered BRAM write: strobe for one cycle, data/address hold after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            din_q    <= '0;
            addra_q  <= '0;
        end else begin
            strobe_q <= accept;
            if (accept) begin
                din_q   <= bus.s_axis_tdata;
                addra_q <= {ptr_q[ADDR_W-1:0], 2'b00};
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of accepted words; settles on the edge load_done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (arm) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + bus.s_axis_tdata;
        end
    end
`endif

    assign bus.s_axis_tready = (state_q == ST_LOAD);
    assign bus.bram_din      = din_q;
    assign bus.bram_addra    = addra_q;
    assign bus.bram_ena      = strobe_q;
    assign bus.bram_wea      = strobe_q;

    assign busy       = (state_q == ST_LOAD);
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERR);
    assign word_count = ptr_q;
    assign state_dbg  = state_q;

endmodule
